// File: rtl/uart_px_pkg.sv
// Shared types and constants for the uart_px core: FSM state encoding,
// rx_err bit positions and the legal parameter ranges.
package uart_px_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_FRAME   = 0;
  localparam int unsigned ERR_PARITY  = 1;
  localparam int unsigned ERR_OVERRUN = 2;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned DATA_W_MAX = 9;
  localparam int unsigned OVS_MIN    = 8;
  localparam int unsigned OVS_MAX    = 16;

endpackage

// File: rtl/uart_px_baud.sv
// Oversample tick generator: one-clock pulse every baud_div+1 clocks.
// A new baud_div is only picked up when the down-counter reloads.
module uart_px_baud #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_l,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= baud_div;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_px_core.sv
// Oversampled UART TX/RX core with valid/ready byte interfaces.
// Define UART_PX_PARITY_EN to add the parity_odd input and a parity bit per frame.
module uart_px_core
  import uart_px_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              stop2,
`ifdef UART_PX_PARITY_EN
  input  logic              parity_odd,
`endif
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              uart_txd,
  input  logic              uart_rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ERR_W-1:0]  rx_err
);

  localparam int unsigned CNT_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVS / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_PX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic tick;

  uart_px_baud #(.DIV_W(DIV_W)) u_baud (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .baud_div  (baud_div),
    .tick      (tick)
  );

  // ---------------------------------------------------------------- TX
  uart_state_e       tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_tick_q;
  logic [BIT_W-1:0]  tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_armed_q, tx_stop2_q, tx_second_q, txd_q, run_q;
  logic              tx_fire, tx_bit_end, tx_tail_bit;

`ifdef UART_PX_PARITY_EN
  logic tx_par_q;
  assign tx_tail_bit = tx_par_q;
`else
  assign tx_tail_bit = 1'b1;
`endif

  assign tx_ready   = run_q && (tx_state_q == ST_IDLE);
  assign tx_fire    = tx_valid && tx_ready;
  assign tx_bit_end = tick && tx_armed_q && (tx_tick_q == TICK_LAST);
  assign uart_txd   = txd_q;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tx_state_q <= ST_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      ST_IDLE:   if (tx_fire) tx_state_d = ST_START;
      ST_START:  if (tx_bit_end) tx_state_d = ST_DATA;
      ST_DATA:   if (tx_bit_end && (tx_bit_q == BIT_LAST)) tx_state_d = AFTER_DATA;
      ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
      ST_STOP:   if (tx_bit_end && (tx_second_q || !tx_stop2_q)) tx_state_d = ST_IDLE;
      default:   tx_state_d = ST_IDLE;
    endcase
  end

  // START waits unarmed for the first tick so every cell is exactly OVS ticks long.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      run_q       <= 1'b0;
      txd_q       <= 1'b1;
      tx_armed_q  <= 1'b0;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
`ifdef UART_PX_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (tx_state_q == ST_IDLE) begin
        txd_q      <= 1'b1;
        tx_armed_q <= 1'b0;
        tx_tick_q  <= '0;
        if (tx_fire) begin
          tx_shift_q  <= tx_data;
          tx_stop2_q  <= stop2;
          tx_bit_q    <= '0;
          tx_second_q <= 1'b0;
`ifdef UART_PX_PARITY_EN
          tx_par_q    <= (^tx_data) ^ parity_odd;
`endif
        end
      end else if (tick) begin
        if (!tx_armed_q) begin
          tx_armed_q <= 1'b1;
          txd_q      <= 1'b0;
        end else if (tx_tick_q != TICK_LAST) begin
          tx_tick_q <= tx_tick_q + 1'b1;
        end else begin
          tx_tick_q <= '0;
          case (tx_state_q)
            ST_START: txd_q <= tx_shift_q[0];
            ST_DATA: begin
              if (tx_bit_q == BIT_LAST) begin
                txd_q <= tx_tail_bit;
              end else begin
                txd_q      <= tx_shift_q[1];
                tx_shift_q <= tx_shift_q >> 1;
                tx_bit_q   <= tx_bit_q + 1'b1;
              end
            end
            ST_PARITY: txd_q <= 1'b1;
            ST_STOP: begin
              txd_q       <= 1'b1;
              tx_second_q <= 1'b1;
            end
            default: txd_q <= 1'b1;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX
  uart_state_e       rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_tick_q;
  logic [BIT_W-1:0]  rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rxd_meta_q, rxd_sync_q, rxd_prev_q, rx_wait_high_q;
  logic              rx_fall, rx_mid, rx_end, rx_stop_sample, rx_load, rx_valid_d;
  logic [ERR_W-1:0]  rx_err_d;

`ifdef UART_PX_PARITY_EN
  logic rx_par_err_q;
`endif

  assign rx_fall        = rxd_prev_q && !rxd_sync_q;
  assign rx_mid         = tick && (rx_tick_q == TICK_MID);
  assign rx_end         = tick && (rx_tick_q == TICK_LAST);
  assign rx_stop_sample = (rx_state_q == ST_STOP) && !rx_wait_high_q && rx_mid;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_state_q <= ST_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      ST_IDLE: if (rx_fall) rx_state_d = ST_START;
      ST_START: begin
        if (rx_mid && rxd_sync_q) rx_state_d = ST_IDLE;
        else if (rx_end) rx_state_d = ST_DATA;
      end
      ST_DATA:   if (rx_end && (rx_bit_q == BIT_LAST)) rx_state_d = AFTER_DATA;
      ST_PARITY: if (rx_end) rx_state_d = ST_STOP;
      ST_STOP: begin
        if (rx_wait_high_q) begin
          if (rxd_sync_q) rx_state_d = ST_IDLE;
        end else if (rx_mid && rxd_sync_q) begin
          rx_state_d = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A handshake in the same cycle as a stop sample frees the buffer for the new frame.
  always_comb begin
    rx_valid_d = rx_valid;
    rx_err_d   = rx_err;
    rx_load    = 1'b0;
    if (rx_valid && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_err_d   = '0;
    end
    if (rx_stop_sample) begin
      if (rx_valid_d) begin
        rx_err_d[ERR_OVERRUN] = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_load    = 1'b1;
      end
      if (!rxd_sync_q) rx_err_d[ERR_FRAME] = 1'b1;
`ifdef UART_PX_PARITY_EN
      if (rx_par_err_q) rx_err_d[ERR_PARITY] = 1'b1;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rxd_meta_q     <= 1'b1;
      rxd_sync_q     <= 1'b1;
      rxd_prev_q     <= 1'b1;
      rx_tick_q      <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_wait_high_q <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_err         <= '0;
`ifdef UART_PX_PARITY_EN
      rx_par_err_q   <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_valid   <= rx_valid_d;
      rx_err     <= rx_err_d;
      if (rx_load) rx_data <= rx_shift_q;
      if (rx_state_q == ST_IDLE) begin
        rx_tick_q      <= '0;
        rx_bit_q       <= '0;
        rx_wait_high_q <= 1'b0;
`ifdef UART_PX_PARITY_EN
        rx_par_err_q   <= 1'b0;
`endif
      end else if (tick) begin
        rx_tick_q <= (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + 1'b1;
        if (rx_end && (rx_state_q == ST_DATA)) rx_bit_q <= rx_bit_q + 1'b1;
        if (rx_mid) begin
          case (rx_state_q)
            ST_DATA: rx_shift_q <= {rxd_sync_q, rx_shift_q[DATA_W-1:1]};
`ifdef UART_PX_PARITY_EN
            ST_PARITY: rx_par_err_q <= rxd_sync_q != ((^rx_shift_q) ^ parity_odd);
`endif
            ST_STOP: if (!rxd_sync_q) rx_wait_high_q <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
